// File: rtl/bus_arbiter_4way.sv
// Four-way round-robin bus arbiter driving a one-hot grant, encoded select and bus enable.
// Define ARB_HOLD_LIMIT_EN to cap an owner's tenure at MAX_HOLD cycles while others wait.
module bus_arbiter_4way #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       bus_en
);

    // state | meaning
    // IDLE  | no owner, grant all-zero, sel holds last owner
    // OWNED | one owner, grant one-hot at sel, bus_en high
    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q;
    logic [3:0] grant_q;
    logic [1:0] sel_q;
    logic       bus_en_q;
    logic [1:0] ptr_q;

    logic       pick_vld;
    logic [1:0] pick_idx;
    logic       owner_req;
    logic       hold_expired;
    logic       handoff;

    // Descending offsets so the smallest offset from ptr wins the search.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            logic [1:0] idx;
            idx = ptr_q + 2'(i);
            if (req[idx]) begin
                pick_vld = 1'b1;
                pick_idx = idx;
            end
        end
    end

    assign owner_req = req[sel_q];

`ifdef ARB_HOLD_LIMIT_EN
    logic [7:0] hold_q;
    logic       others_req;

    assign others_req   = |(req & ~grant_q);
    assign hold_expired = (hold_q == HOLD_LAST) && others_req;
`else
    logic unused_hold;

    assign unused_hold  = ^HOLD_LAST;
    assign hold_expired = 1'b0;
`endif

    assign handoff = (state_q == IDLE) || !owner_req || hold_expired;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= 4'b0000;
            sel_q    <= 2'b00;
            bus_en_q <= 1'b0;
            ptr_q    <= 2'b00;
`ifdef ARB_HOLD_LIMIT_EN
            hold_q   <= 8'd0;
`endif
        end else if (handoff) begin
            if (pick_vld) begin
                state_q  <= OWNED;
                grant_q  <= 4'b0001 << pick_idx;
                sel_q    <= pick_idx;
                bus_en_q <= 1'b1;
                ptr_q    <= pick_idx + 2'd1;
            end else begin
                state_q  <= IDLE;
                grant_q  <= 4'b0000;
                bus_en_q <= 1'b0;
            end
`ifdef ARB_HOLD_LIMIT_EN
            hold_q <= 8'd0;
`endif
        end else begin
`ifdef ARB_HOLD_LIMIT_EN
            // Saturates so a lone owner keeps the bus indefinitely.
            if (hold_q != HOLD_LAST) begin
                hold_q <= hold_q + 8'd1;
            end
`endif
        end
    end

    assign grant  = grant_q;
    assign sel    = sel_q;
    assign bus_en = bus_en_q;

endmodule

// File: tb/tb_bus_arbiter_4way.sv
// Directed bench for bus_arbiter_4way; hold-limit scenarios run when ARB_HOLD_LIMIT_EN is defined.
module tb_bus_arbiter_4way;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int unsigned MAX_HOLD = 2;
`else
    localparam int unsigned MAX_HOLD = 8;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       bus_en;

    int errors = 0;
    int checks = 0;

    bus_arbiter_4way #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .grant  (grant),
        .sel    (sel),
        .bus_en (bus_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compares the whole output bundle {bus_en, sel, grant}.
    task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s, input logic e);
        chk(tag, {1'b0, bus_en, sel, grant}, {1'b0, e, s, g});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;

        step();
        chk_out("reset_edge1", 4'b0000, 2'b00, 1'b0);
        step();
        chk_out("reset_edge2", 4'b0000, 2'b00, 1'b0);
        rst_n = 1'b1;
        step();
        chk_out("reset_release", 4'b0001, 2'b00, 1'b1);

        do_reset();
        req = 4'b0110;
        step();
        chk_out("handoff_own1", 4'b0010, 2'b01, 1'b1);
        req = 4'b0100;
        step();
        chk_out("handoff_to2", 4'b0100, 2'b10, 1'b1);
        req = 4'b0000;
        step();
        chk_out("handoff_idle", 4'b0000, 2'b10, 1'b0);

        req = 4'b0001;
        #2 req = 4'b0000;
        step();
        chk_out("short_pulse", 4'b0000, 2'b10, 1'b0);

        do_reset();
        req = 4'b1011;
        step();
        chk_out("rr_own0", 4'b0001, 2'b00, 1'b1);
        req = 4'b1010;
        step();
        chk_out("rr_own1", 4'b0010, 2'b01, 1'b1);
        req = 4'b1001;
        step();
        chk_out("rr_skip0_own3", 4'b1000, 2'b11, 1'b1);
        req = 4'b0001;
        step();
        chk_out("rr_wrap0", 4'b0001, 2'b00, 1'b1);

        do_reset();
        req = 4'b0100;
        step();
        chk_out("midrst_own2", 4'b0100, 2'b10, 1'b1);
        rst_n = 1'b0;
        step();
        chk_out("midrst_drop", 4'b0000, 2'b00, 1'b0);
        rst_n = 1'b1;
        req   = 4'b1001;
        step();
        chk_out("midrst_ptr0", 4'b0001, 2'b00, 1'b1);
        req = 4'b0100;
        step();
        chk_out("midrst_own2b", 4'b0100, 2'b10, 1'b1);

        do_reset();
        req = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_out("sat_hold3", 4'b1000, 2'b11, 1'b1);
        end
        req = 4'b1001;
        step();
`ifdef ARB_HOLD_LIMIT_EN
        chk_out("sat_handoff0", 4'b0001, 2'b00, 1'b1);
`else
        chk_out("nolimit_keep3", 4'b1000, 2'b11, 1'b1);
        req = 4'b0001;
        step();
        chk_out("nolimit_rel3", 4'b0001, 2'b00, 1'b1);
`endif

`ifdef ARB_HOLD_LIMIT_EN
        begin
            logic [1:0] exp_seq [9];
            exp_seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
            do_reset();
            req = 4'b1111;
            for (int i = 0; i < 9; i++) begin
                step();
                chk_out($sformatf("rr_hold_%0d", i), 4'b0001 << exp_seq[i], exp_seq[i], 1'b1);
            end
        end
`else
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 30; i++) begin
            step();
            chk_out("nolimit_own0", 4'b0001, 2'b00, 1'b1);
        end
        req = 4'b0010;
        step();
        chk_out("nolimit_to1", 4'b0010, 2'b01, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_4way.md
BUS_ARBITER_4WAY -- requirements
Module: bus_arbiter_4way

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, meaning the maximum consecutive grant cycles per owner while another requester waits (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-004 The block SHALL have port req, input, 4, one request bit per source d0..d3.
REQ-005 The block SHALL have port grant, output, 4, one-hot grant, all-zero when idle.
REQ-006 The block SHALL have port sel, output, 2, encoded owner index; drives s of the downstream four-way tristate mux.
REQ-007 The block SHALL have port bus_en, output, 1, high exactly when grant is non-zero; enables the mux output.

Function
REQ-008 The block SHALL implement two states: IDLE (no owner) and OWNED (one owner).
REQ-009 All outputs SHALL be registered; grant, sel and bus_en SHALL change only on a clk rising edge.
REQ-010 In IDLE with req non-zero at an edge, the block SHALL enter OWNED and grant the first requester found searching upward from index ptr with wrap (ptr, ptr+1, ... mod 4); latency is 1 cycle from req to grant.
REQ-011 On every new grant to index k, ptr SHALL become (k+1) mod 4; a requester SHALL never wait more than 3 grant tenures.
REQ-012 In OWNED, if req[owner] is low at an edge, the block SHALL grant the next requester by the REQ-010 search on that same edge with no idle cycle, or return to IDLE if req is zero.
REQ-013 In OWNED, the hold counter SHALL increment each cycle the owner keeps the grant, and SHALL clear to 0 on every new grant.
REQ-014 When the hold counter equals MAX_HOLD-1 and req[owner] is high and another req bit is high, the block SHALL move the grant to the next requester by REQ-010 at that edge.
REQ-015 When the hold counter equals MAX_HOLD-1 and no other req bit is high, the owner SHALL keep the grant and the counter SHALL saturate at MAX_HOLD-1.
REQ-016 sel SHALL equal the owner index in OWNED and SHALL retain its last value in IDLE.
REQ-017 grant SHALL never have more than one bit set; bus_en SHALL equal the OR of grant.
REQ-018 Request bits SHALL be treated as level-sensitive; a pulse shorter than one cycle between edges SHALL be ignored.

Reset
REQ-019 With rst_n low at an edge: state=IDLE, grant=4'b0000, sel=2'b00, bus_en=0, ptr=0, hold counter=0.
REQ-020 Reset asserted mid-tenure SHALL drop the grant at that edge regardless of req; arbitration SHALL resume from ptr=0 on the first edge with rst_n high.

Configuration
REQ-021 Macro ARB_HOLD_LIMIT_EN SHALL control the hold limit.
REQ-022 When ARB_HOLD_LIMIT_EN is defined, REQ-013..REQ-015 SHALL apply.
REQ-023 When ARB_HOLD_LIMIT_EN is undefined, the hold counter SHALL be absent, MAX_HOLD SHALL be ignored, and an owner SHALL keep the grant while its req stays high.

Verification
REQ-024 Reset: hold rst_n=0 for 2 cycles with req=4'b1111 -> grant=0000, sel=00, bus_en=0 at both edges; the first edge with rst_n high -> grant=0001, sel=00.
REQ-025 Round-robin: req=4'b1111 held with MAX_HOLD=2, hold limit enabled -> owner sequence 0,0,1,1,2,2,3,3,0 with 2-cycle tenures and no gaps in bus_en.
REQ-026 Release handoff: owner 1 with req=4'b0110, then drop req[1] -> at the next edge grant=0100, sel=10 with no idle cycle; then req=0 -> next edge grant=0000, bus_en=0, sel stays 10.
REQ-027 Saturation: req=4'b1000 alone for 20 cycles, MAX_HOLD=8 -> grant=1000 throughout; raise req[0] at cycle 20 -> grant=0001 at the next edge.
REQ-028 Macro off: build without ARB_HOLD_LIMIT_EN, req=4'b0011 for 30 cycles -> grant stays 0001; drop req[0] -> the next edge gives grant=0010.
REQ-029 Mid-tenure reset: owner 2, pulse rst_n=0 for 1 cycle -> grant=0000 at that edge; with req=4'b0100 the next edge gives grant=0100, found by searching from ptr=0.
